mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access unit bridging the execute stage to a split addr/data memory bus
//
// Purpose:
//   Accepts one memory op at a time from the execute stage and issues it on a
//   request/address-ok/data-ok bus. Store data is replicated across byte lanes
//   with a matching write strobe. Load data is extracted from the returned word
//   and sign- or zero-extended. A flush during the bus phase still lets the
//   transaction finish on the bus but suppresses the completion pulse.
//
// Optional feature (macro LSU_ADDR_EXC_EN):
//   defined   - misaligned half/word accesses skip the bus and report adel/ades
//               with badvaddr one cycle after accept.
//   undefined - adel/ades/badvaddr tie to 0 and misaligned accesses go out with
//               the address rounded down to the access size.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   op_valid, op, addr, wdata   memory op from execute (op code, EA, store value)
//   flush                       cancel the in-flight op's result
//   op_ready, stall             idle/accepting, pipeline hold request
//   result_valid, result        one-cycle completion pulse, extended load data
//   adel, ades, badvaddr        address-error pulses and faulting address
//   data_req, data_wr           bus request, 1 = write
//   data_size                   0 byte, 1 half, 2 word
//   data_addr, data_wdata       bus address, lane-replicated write data
//   data_wstrb                  write byte enables (0 for reads)
//   data_addr_ok, data_data_ok  address accepted, data returned/written
//   data_rdata                  read word
module mem_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      r_state;
  logic        r_cancel;
  logic        r_load;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;

  logic        w_is_mem;
  logic        w_is_load;
  logic        w_signed;
  logic [1:0]  w_size;
  logic        w_accept;
  logic [31:0] w_addr_al;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Op decode
  always_comb begin
    w_is_mem  = 1'b1;
    w_is_load = 1'b1;
    w_signed  = 1'b0;
    w_size    = 2'd0;
    case (op)
      EXE_LB_OP:  begin w_size = 2'd0; w_signed = 1'b1; end
      EXE_LBU_OP: begin w_size = 2'd0; end
      EXE_LH_OP:  begin w_size = 2'd1; w_signed = 1'b1; end
      EXE_LHU_OP: begin w_size = 2'd1; end
      EXE_LW_OP:  begin w_size = 2'd2; end
      EXE_SB_OP:  begin w_size = 2'd0; w_is_load = 1'b0; end
      EXE_SH_OP:  begin w_size = 2'd1; w_is_load = 1'b0; end
      EXE_SW_OP:  begin w_size = 2'd2; w_is_load = 1'b0; end
      default:    begin w_is_mem = 1'b0; w_is_load = 1'b0; end
    endcase
  end

  assign w_accept = (r_state == IDLE) && op_valid && w_is_mem && !flush;

  // Bus address is always size-aligned; lane selection uses the original low bits
  always_comb begin
    w_addr_al = addr;
    w_wdata   = wdata;
    w_strb    = 4'b1111;
    case (w_size)
      2'd0: begin
        w_wdata = {4{wdata[7:0]}};
        w_strb  = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        w_addr_al = {addr[31:1], 1'b0};
        w_wdata   = {2{wdata[15:0]}};
        w_strb    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_addr_al = {addr[31:2], 2'b00};
      end
    endcase
  end

`ifdef LSU_ADDR_EXC_EN
  logic w_misal;
  assign w_misal = ((w_size == 2'd1) && addr[0]) ||
                   ((w_size == 2'd2) && (addr[1:0] != 2'b00));
`endif

  // Load extraction from the returned word
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = data_rdata[7:0];
      2'd1:    w_byte = data_rdata[15:8];
      2'd2:    w_byte = data_rdata[23:16];
      default: w_byte = data_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_size)
      2'd0:    w_ext = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      2'd1:    w_ext = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default: w_ext = data_rdata;
    endcase
  end

  assign op_ready = (r_state == IDLE);
  // Gated by resetn so the hold request drops while reset is asserted
  assign stall    = resetn && ((r_state != IDLE) || (op_valid && w_is_mem));

`ifndef LSU_ADDR_EXC_EN
  assign adel     = 1'b0;
  assign ades     = 1'b0;
  assign badvaddr = 32'd0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_cancel     <= 1'b0;
      r_load       <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'd0;
      r_addr_lo    <= 2'd0;
      result_valid <= 1'b0;
      result       <= 32'd0;
      data_req     <= 1'b0;
      data_wr      <= 1'b0;
      data_size    <= 2'd0;
      data_addr    <= 32'd0;
      data_wdata   <= 32'd0;
      data_wstrb   <= 4'd0;
`ifdef LSU_ADDR_EXC_EN
      adel         <= 1'b0;
      ades         <= 1'b0;
      badvaddr     <= 32'd0;
`endif
    end else begin
      result_valid <= 1'b0;
`ifdef LSU_ADDR_EXC_EN
      adel         <= 1'b0;
      ades         <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cancel <= 1'b0;
          if (w_accept) begin
            r_load    <= w_is_load;
            r_signed  <= w_signed;
            r_size    <= w_size;
            r_addr_lo <= addr[1:0];
`ifdef LSU_ADDR_EXC_EN
            if (w_misal) begin
              // Address error: no bus traffic, report straight from DONE
              r_state      <= DONE;
              result_valid <= 1'b1;
              result       <= 32'd0;
              adel         <= w_is_load;
              ades         <= !w_is_load;
              badvaddr     <= addr;
            end else
`endif
            begin
              r_state    <= REQ;
              data_req   <= 1'b1;
              data_wr    <= !w_is_load;
              data_size  <= w_size;
              data_addr  <= w_addr_al;
              data_wdata <= w_wdata;
              data_wstrb <= w_is_load ? 4'd0 : w_strb;
            end
          end
        end
        REQ: begin
          if (flush) r_cancel <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (flush) r_cancel <= 1'b1;
          if (data_data_ok) begin
            r_state      <= DONE;
            result_valid <= !(r_cancel || flush);
            result       <= r_load ? w_ext : 32'd0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
